// File: rtl/pc_ctrl.sv
// Next-PC select, pipeline stall/flush control and mult/div busy tracking.
// Optional fetch-alignment check is enabled by defining PC_ALIGN_CHECK_EN.
module pc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    input  logic        stall_hazard,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        md_use,
    output logic [31:0] npc,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_flush,
    output logic        md_busy,
    output logic        exc_adel
);

    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 4;

    localparam logic [CNT_W-1:0] MULT_CYCLES = CNT_W'(5);
    localparam logic [CNT_W-1:0] DIV_CYCLES  = CNT_W'(10);
    localparam logic [PC_W-1:0]  PC_STEP     = PC_W'(4);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             md_busy_q, md_busy_d;

    logic             stall_c;
    logic             redirect_c;
    logic [PC_W-1:0]  target_c;
    logic [PC_W-1:0]  seq_pc_c;

    // Mult/div state register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_RUN;
            md_cnt_q  <= '0;
            md_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            md_cnt_q  <= md_cnt_d;
            md_busy_q <= md_busy_d;
        end
    end

    // md_start is only honoured from RUN; the counter holds remaining busy cycles.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            S_RUN: begin
                if (md_start) begin
                    md_cnt_d = md_is_div ? DIV_CYCLES : MULT_CYCLES;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (md_cnt_q == CNT_W'(1)) begin
                    md_cnt_d = '0;
                    state_d  = S_RUN;
                end else begin
                    md_cnt_d = md_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                md_cnt_d = '0;
                state_d  = S_RUN;
            end
        endcase
        md_busy_d = (state_d == S_BUSY);
    end

    assign md_busy = md_busy_q;

    // HI/LO readers wait only while the unit is actually busy.
    assign stall_c     = stall_hazard | (md_use & md_busy_q);
    assign pc_en       = ~stall_c;
    assign if_id_en    = ~stall_c;
    assign id_ex_flush = stall_c;

    // Redirect priority: jr > j/jal > taken branch; no IF/ID flush (delay slot runs).
    always_comb begin
        redirect_c = 1'b1;
        target_c   = jr_target;
        if (jr) begin
            target_c = jr_target;
        end else if (jmp) begin
            target_c = jmp_target;
        end else if (br_taken) begin
            target_c = br_target;
        end else begin
            redirect_c = 1'b0;
        end
    end

    assign seq_pc_c = pc_cur + PC_STEP;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [PC_W-1:0] EXC_VECTOR = PC_W'(32'h0000_4180);

    logic misaligned_c;

    assign misaligned_c = redirect_c & (target_c[1:0] != 2'b00) & ~stall_c;
    assign exc_adel     = misaligned_c;

    always_comb begin
        npc = seq_pc_c;
        if (misaligned_c) begin
            npc = EXC_VECTOR;
        end else if (redirect_c) begin
            npc = target_c;
        end
    end
`else
    assign exc_adel = 1'b0;
    assign npc      = redirect_c ? target_c : seq_pc_c;
`endif

endmodule
